// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
//   Bundles the command, response and APB signals of apb_master_bridge.
//   Modports:
//     master : the bridge's view (drives cmd_ready, rsp_*, psel/penable/
//              pwrite/paddr/pwdata; receives cmd_*, rsp_ready, prdata/pready)
//     slave  : the environment's view (command source, response sink and
//              APB responder combined)
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   // Command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   // Response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   // APB requester side
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );

endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Converts single valid/ready commands into APB transfers (SETUP, ACCESS)
//   and returns one response per command. An ACCESS phase that sees pready
//   low for longer than TIMEOUT cycles is aborted with rsp_err=1.
//   Ports:
//     pclk   : sole clock, rising edge
//     preset : synchronous active-high reset
//     bus    : apb_master_bridge_if.master (command, response, APB signals)
//   Parameters:
//     ADDR_W, DATA_W : APB address / data width
//     TIMEOUT        : max ACCESS wait cycles before abort, 0 = wait forever
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  pclk,
   input  logic                  preset,
   apb_master_bridge_if.master   bus
);

   // A zero TIMEOUT still needs a legal 1-bit counter; it is simply never
   // compared against.
   localparam int              WAIT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit              TO_EN      = (TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [WAIT_W-1:0] r_wait;

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_wait    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  // Address, direction and data are frozen here and stay
                  // untouched until the next accepted command.
                  r_pwrite  <= bus.cmd_write;
                  r_paddr   <= bus.cmd_addr;
                  r_pwdata  <= bus.cmd_wdata;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_wait    <= '0;
                  r_state   <= SETUP;
               end
            end

            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end

            ACCESS: begin
               // pready has priority over the timeout check, so a responder
               // answering on the last allowed cycle still completes cleanly.
               if (bus.pready) begin
                  r_rdata   <= r_pwrite ? '0 : bus.prdata;
                  r_err     <= 1'b0;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= RESP;
               end else if (TO_EN && (r_wait == WAIT_LIMIT)) begin
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= RESP;
               end else if (r_wait != WAIT_MAX) begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  r_state <= IDLE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   // Handshake flags are pure state decodes; everything else is a register.
   assign bus.cmd_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;
   assign bus.psel      = r_psel;
   assign bus.penable   = r_penable;
   assign bus.pwrite    = r_pwrite;
   assign bus.paddr     = r_paddr;
   assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed stimulus for apb_master_bridge (TIMEOUT=4) plus a second
//   instance with TIMEOUT=0. Each command pushes its expected APB setup and
//   its expected response; a negedge monitor plays the APB responder and
//   the response sink, and compares everything the DUT presents.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ws;     // wait states before pready; -1 = never
      logic [31:0] rdv;    // prdata returned with pready
   } apb_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;    // cycles from accept to first rsp_valid
      int          bp;     // cycles rsp_ready is held low
   } exp_t;

   logic pclk   = 1'b0;
   logic preset = 1'b1;
   int   cyc    = 0;

   int n_pass  = 0;
   int n_total = 0;

   apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
   apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

   apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus.master)
   );

   apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut0 (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus0.master)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   apb_t apb_q[$];
   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_log[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ---------------------------------------------------------------- monitor
   apb_t        cur_apb;
   exp_t        cur_exp;
   int          acc_cnt   = 0;
   int          bp_cnt    = 0;
   bit          in_resp   = 0;
   bit          prev_psel = 0;
   bit          prev_setup = 0;
   logic [31:0] held_rdata;
   logic        held_err;

   always @(negedge pclk) begin
      if (preset) begin
         bus.pready    = 1'b1;
         bus.prdata    = 32'hBAD0_0BAD;
         bus.rsp_ready = 1'b1;
         in_resp       = 0;
         prev_psel     = 0;
         prev_setup    = 0;
         acc_cnt       = 0;
      end else begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
         end

         // APB phase checks
         if (bus.psel && !bus.penable) begin
            chk("setup_one_cycle", prev_setup, 0);
            if (apb_q.size() == 0) begin
               chk("unexpected_setup", bus.psel, 0);
            end else begin
               cur_apb = apb_q.pop_front();
               chk("setup_paddr", bus.paddr, cur_apb.addr);
               chk("setup_pwrite", bus.pwrite, cur_apb.w);
               chk("setup_pwdata", bus.pwdata, cur_apb.wdata);
            end
            acc_cnt = 0;
         end
         if (bus.psel && bus.penable) begin
            chk("access_after_setup", prev_psel, 1);
            chk("access_paddr_stable", bus.paddr, cur_apb.addr);
            chk("access_pwdata_stable", bus.pwdata, cur_apb.wdata);
            chk("access_pwrite_stable", bus.pwrite, cur_apb.w);
         end
         if (!bus.psel && bus.penable) chk("penable_without_psel", bus.penable, 0);

         // Responder: junk with pready=1 outside ACCESS must be ignored
         if (bus.psel && bus.penable) begin
            bus.pready = (cur_apb.ws >= 0) && (acc_cnt == cur_apb.ws);
            bus.prdata = bus.pready ? cur_apb.rdv : 32'hBAD0_0BAD;
            acc_cnt++;
         end else begin
            bus.pready = 1'b1;
            bus.prdata = 32'hBAD0_0BAD;
         end

         // Response checks and sink
         if (bus.rsp_valid) begin
            chk("rsp_no_psel", bus.psel, 0);
            chk("rsp_cmd_ready_low", bus.cmd_ready, 0);
            if (!in_resp) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", bus.rsp_valid, 0);
                  cur_exp.bp = 0;
               end else begin
                  cur_exp = exp_q.pop_front();
                  if (acc_q.size() != 0) chk("rsp_latency", cyc - acc_q.pop_front(), cur_exp.lat);
                  chk("rsp_rdata", bus.rsp_rdata, cur_exp.rdata);
                  chk("rsp_err", bus.rsp_err, cur_exp.err);
               end
               held_rdata = bus.rsp_rdata;
               held_err   = bus.rsp_err;
               bp_cnt     = 0;
               in_resp    = 1;
            end else begin
               chk("rsp_rdata_stable", bus.rsp_rdata, held_rdata);
               chk("rsp_err_stable", bus.rsp_err, held_err);
            end
            bus.rsp_ready = (bp_cnt >= cur_exp.bp);
            bp_cnt++;
            if (bus.rsp_ready) in_resp = 0;
         end else begin
            bus.rsp_ready = 1'b1;
            in_resp       = 0;
         end

         prev_psel  = bus.psel;
         prev_setup = bus.psel && !bus.penable;
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input int ws, input logic [31:0] rdv,
                       input logic [31:0] erd, input logic eerr, input int elat,
                       input int bp, input bit keep);
      apb_t ap;
      exp_t ex;
      int   n;
      ap.w = w; ap.addr = a; ap.wdata = wd; ap.ws = ws; ap.rdv = rdv;
      ex.rdata = erd; ex.err = eerr; ex.lat = elat; ex.bp = bp;
      apb_q.push_back(ap);
      exp_q.push_back(ex);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!bus.cmd_ready && n < 200);
      if (!bus.cmd_ready) chk("cmd_accept_timeout", bus.cmd_ready, 1);
      @(posedge pclk);
      #1;
      if (!keep) bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && n < 300) begin
         @(posedge pclk);
         n++;
      end
      #1;
      if (n >= 300) chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_write  = 1'b0;
      bus.cmd_addr   = '0;
      bus.cmd_wdata  = '0;
      bus0.cmd_valid = 1'b0;
      bus0.cmd_write = 1'b0;
      bus0.cmd_addr  = '0;
      bus0.cmd_wdata = '0;
      bus0.pready    = 1'b0;
      bus0.prdata    = '0;
      bus0.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_psel", bus.psel, 0);
      chk("rst_penable", bus.penable, 0);
      chk("rst_pwrite", bus.pwrite, 0);
      chk("rst_paddr", bus.paddr, 0);
      chk("rst_pwdata", bus.pwdata, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      preset = 1'b0;
      @(posedge pclk);
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, 1);

      // Read, pready immediately
      send(1'b0, 32'h4, 32'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 0, 1'b0);
      drain();
      // Write with 3 wait states: rdata must be 0 although prdata is nonzero
      send(1'b1, 32'h8, 32'h1234_5678, 3, 32'hCAFE_F00D, 32'h0, 1'b0, 6, 0, 1'b0);
      drain();
      // Timeout: pready never comes
      send(1'b0, 32'h20, 32'h0, -1, 32'h0, 32'h0, 1'b1, 7, 0, 1'b0);
      drain();
      // pready on the last allowed cycle wins over the timeout
      send(1'b0, 32'h24, 32'h0, 4, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 7, 0, 1'b0);
      drain();
      // Response backpressure, next command waiting behind it
      send(1'b0, 32'h30, 32'h0, 1, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 4, 5, 1'b0);
      send(1'b1, 32'h34, 32'hDEAD_0001, 0, 32'h1111_1111, 32'h0, 1'b0, 3, 0, 1'b0);
      drain();

      // Back-to-back with cmd_valid held high
      acc_log.delete();
      send(1'b0, 32'h40, 32'h0, 0, 32'h0000_0001, 32'h0000_0001, 1'b0, 3, 0, 1'b1);
      send(1'b1, 32'h44, 32'hA0A0_A0A0, 0, 32'h7, 32'h0, 1'b0, 3, 0, 1'b1);
      send(1'b0, 32'h48, 32'h0, 0, 32'h8000_0000, 32'h8000_0000, 1'b0, 3, 0, 1'b1);
      send(1'b1, 32'h4C, 32'h0F0F_0F0F, 0, 32'h9, 32'h0, 1'b0, 3, 0, 1'b0);
      drain();
      chk("b2b_count", acc_log.size(), 4);
      for (int i = 0; i + 1 < acc_log.size(); i++)
         chk("b2b_spacing", acc_log[i+1] - acc_log[i], 4);

      // Reset during ACCESS: no response may follow
      send(1'b1, 32'hF0, 32'h7777_7777, -1, 32'h0, 32'h0, 1'b1, 7, 0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (bus.psel && bus.penable) break;
         @(posedge pclk);
         #1;
      end
      chk("pre_rst_in_access", bus.penable, 1);
      preset = 1'b1;
      @(posedge pclk);
      #1;
      exp_q.delete();
      acc_q.delete();
      apb_q.delete();
      chk("midrst_psel", bus.psel, 0);
      chk("midrst_penable", bus.penable, 0);
      chk("midrst_rsp_valid", bus.rsp_valid, 0);
      chk("midrst_pwrite", bus.pwrite, 0);
      chk("midrst_paddr", bus.paddr, 0);
      chk("midrst_pwdata", bus.pwdata, 0);
      @(posedge pclk);
      #1;
      preset = 1'b0;
      @(posedge pclk);
      #1;
      chk("midrst_cmd_ready", bus.cmd_ready, 1);
      repeat (10) @(posedge pclk);
      #1;
      chk("midrst_no_rsp", bus.rsp_valid, 0);
      send(1'b0, 32'h100, 32'h0, 2, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 5, 0, 1'b0);
      drain();

      // TIMEOUT=0 waits indefinitely in ACCESS
      bus0.cmd_valid = 1'b1;
      bus0.cmd_write = 1'b0;
      bus0.cmd_addr  = 32'h10;
      @(posedge pclk);
      #1;
      bus0.cmd_valid = 1'b0;
      repeat (40) @(posedge pclk);
      #1;
      chk("to0_psel", bus0.psel, 1);
      chk("to0_penable", bus0.penable, 1);
      chk("to0_rsp_valid", bus0.rsp_valid, 0);
      bus0.prdata = 32'hA5A5_5A5A;
      bus0.pready = 1'b1;
      @(posedge pclk);
      #1;
      bus0.pready = 1'b0;
      chk("to0_done_valid", bus0.rsp_valid, 1);
      chk("to0_done_rdata", bus0.rsp_rdata, 32'hA5A5_5A5A);
      chk("to0_done_err", bus0.rsp_err, 0);
      @(posedge pclk);
      #1;
      chk("to0_idle", bus0.cmd_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
